// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encoding and default width.
package nonrestoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/nonrestoring_divider_addsub.sv
// Combinational adder/subtractor: o_sum = i_a + i_b when i_sub=0, i_a - i_b when i_sub=1.
module nonrestoring_divider_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sub,
  output logic [N-1:0] o_sum
);

  assign o_sum = i_a + (i_b ^ {N{i_sub}}) + {{(N-1){1'b0}}, i_sub};

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned radix-2 non-restoring divider with start/busy/done handshake.
// Handshake: start is sampled only in IDLE or DONE; busy covers RUN/FIX; done is a one-cycle result-valid pulse.
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           o_dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remout;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_fix;
  logic             w_sub;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_zero   = (divisor == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // One shared adder: RUN feeds the shifted remainder, FIX feeds R unchanged and always adds.
  always_comb begin
    w_a   = r_rem;
    w_sub = 1'b0;
    if (r_state == S_RUN) begin
      w_a   = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
      w_sub = ~r_rem[WIDTH];
    end
  end

  nonrestoring_divider_addsub #(.N(WIDTH + 1)) u_addsub (
    .i_a   (w_a),
    .i_b   ({1'b0, r_d}),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  assign w_fix = r_rem[WIDTH] ? w_sum : r_rem;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = w_zero ? S_DONE : S_RUN;
        else          w_next = S_IDLE;
      end
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remout <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_zero) begin
              r_quot   <= '1;
              r_remout <= dividend;
              r_dbz    <= 1'b1;
            end else begin
              r_d   <= divisor;
              r_q   <= dividend;
              r_rem <= '0;
              r_cnt <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_rem    <= w_fix;
          r_quot   <= r_q;
          r_remout <= w_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remout;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed and random checks of nonrestoring_divider against an arithmetic reference model.
module tb_nonrestoring_divider;
  import nonrestoring_divider_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  state_t       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W:0] exp_q[$];

  always #5 clk = ~clk;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and returns in the cycle where done is high (or after timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int glitch);
    int n;
    int busy_n;
    logic [2*W:0] e;
    logic [2*W:0] o;
    e = (b == 0) ? {1'b1, {W{1'b1}}, a} : {1'b0, a / b, a % b};
    exp_q.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    start    = 1'b0;
    dividend = W'($urandom_range(0, 255));
    divisor  = W'($urandom_range(0, 255));
    check("busy_after_accept", 32'(busy), 32'(b != 0));
    n = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (glitch != 0 && n + 1 == glitch) begin
        start    = 1'b1;
        dividend = 9;
        divisor  = 3;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
      if (busy) busy_n++;
    end
    start = 1'b0;
    check("latency", 32'(n), (b == 0) ? 32'd0 : 32'(W + 1));
    check("busy_cycles", 32'(busy_n), (b == 0) ? 32'd0 : 32'(W));
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      o = {div_by_zero, quotient, remainder};
      check("result", 32'(o), 32'(e));
    end
  endtask

  task automatic finish_op();
    step();
    check("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    logic seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    step();

    run_op(8'd100, 8'd7, 0);   finish_op();
    run_op(8'd255, 8'd1, 0);   finish_op();
    run_op(8'd5, 8'd200, 0);   finish_op();
    run_op(8'd255, 8'd255, 0); finish_op();
    run_op(8'd37, 8'd0, 0);    finish_op();
    run_op(8'd0, 8'd0, 0);     finish_op();
    run_op(8'd0, 8'd9, 0);     finish_op();

    // start pulsed mid-operation must be ignored
    run_op(8'd100, 8'd7, 3);   finish_op();

    // back-to-back: second start in the DONE cycle
    run_op(8'd200, 8'd16, 0);
    run_op(8'd50, 8'd6, 0);    finish_op();

    // reset during RUN discards the operation
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quot", 32'(quotient), 32'd0);
    check("midrst_rem", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      step();
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op(8'd200, 8'd16, 0);  finish_op();

    for (int i = 0; i < 2000; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 0);
      finish_op();
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
